// File: rtl/axi4_read_arbiter_pkg.sv
// Shared encodings for the AXI4-lite read arbiter and its neighbours.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: FSM state encoding and one-hot grant constants {LSU, IFU}.
package axi4_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/axi4_read_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between IFU and LSU requests.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports: req_ifu/req_lsu request levels, last_grant previous owner (one-hot),
//        gnt one-hot pick (GNT_NONE when nobody requests).
module rr_arbiter2
  import axi4_read_arbiter_pkg::*;
(
  input  logic       req_ifu,
  input  logic       req_lsu,
  input  logic [1:0] last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req_ifu && req_lsu) begin
      // Tie: whoever did not own the port last time wins.
      gnt = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    end else if (req_ifu) begin
      gnt = GNT_IFU;
    end else if (req_lsu) begin
      gnt = GNT_LSU;
    end
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Shares one host read port between IFU and LSU with round-robin grant.
// Latency: grant one cycle after request; Finish one cycle after M_Finish.
// Backpressure: requesters hold Request until their Finish pulse; one read in flight.
//
// Ports: CLK/RST_N; IFU_* and LSU_* requester ports (Addr/Request in,
//        Finish/Data out); M_* read-module port (Addr/Request out,
//        Finish/Data in); Grant one-hot owner; Timeout_Err sticky flag.
module axi4_read_arbiter
  import axi4_read_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter bit LSU_FIRST = 1'b1,
  parameter int TIMEOUT   = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] IFU_Addr,
  input  logic              IFU_Request,
  output logic              IFU_Finish,
  output logic [DATA_W-1:0] IFU_Data,
  input  logic [ADDR_W-1:0] LSU_Addr,
  input  logic              LSU_Request,
  output logic              LSU_Finish,
  output logic [DATA_W-1:0] LSU_Data,
  output logic [ADDR_W-1:0] M_Addr,
  output logic              M_Request,
  input  logic              M_Finish,
  input  logic [DATA_W-1:0] M_Data,
  output logic [1:0]        Grant,
  output logic              Timeout_Err
);

  localparam int              CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT > 0);

  arb_state_t        state, state_nxt;
  logic [1:0]        pick;
  logic [1:0]        last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  to_cnt, to_cnt_nxt;
  logic              busy;

  logic              m_req_nxt;
  logic [ADDR_W-1:0] m_addr_nxt;
  logic [1:0]        grant_nxt;
  logic              ifu_fin_nxt, lsu_fin_nxt;
  logic [DATA_W-1:0] ifu_data_nxt, lsu_data_nxt;
  logic              err_nxt;

  assign busy = (state == BUSY_IFU) || (state == BUSY_LSU);

  rr_arbiter2 u_rr (
    .req_ifu    (IFU_Request),
    .req_lsu    (LSU_Request),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. DONE never samples requests so the finished
  // requester has a cycle to drop its Request line.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick == GNT_IFU)      state_nxt = BUSY_IFU;
        else if (pick == GNT_LSU) state_nxt = BUSY_LSU;
      end
      BUSY_IFU, BUSY_LSU: begin
        if (M_Finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    m_req_nxt      = (state_nxt == BUSY_IFU) || (state_nxt == BUSY_LSU);
    grant_nxt      = (state_nxt == BUSY_IFU) ? GNT_IFU :
                     (state_nxt == BUSY_LSU) ? GNT_LSU : GNT_NONE;
    m_addr_nxt     = M_Addr;
    last_grant_nxt = last_grant;
    if (state == IDLE && pick != GNT_NONE) begin
      last_grant_nxt = pick;
      m_addr_nxt     = (pick == GNT_LSU) ? LSU_Addr : IFU_Addr;
    end

    // M_Finish outside BUSY is spurious and must not touch the data registers.
    ifu_fin_nxt  = (state == BUSY_IFU) && M_Finish;
    lsu_fin_nxt  = (state == BUSY_LSU) && M_Finish;
    ifu_data_nxt = ifu_fin_nxt ? M_Data : IFU_Data;
    lsu_data_nxt = lsu_fin_nxt ? M_Data : LSU_Data;

    // Counter saturates at TIMEOUT; the flag is sticky so the read keeps waiting.
    to_cnt_nxt = '0;
    err_nxt    = Timeout_Err;
    if (TO_EN && busy && !M_Finish) begin
      to_cnt_nxt = (to_cnt == TO_VAL) ? to_cnt : to_cnt + CNT_W'(1);
      if (to_cnt_nxt == TO_VAL) err_nxt = 1'b1;
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      M_Request   <= 1'b0;
      M_Addr      <= '0;
      Grant       <= GNT_NONE;
      IFU_Finish  <= 1'b0;
      LSU_Finish  <= 1'b0;
      IFU_Data    <= '0;
      LSU_Data    <= '0;
      Timeout_Err <= 1'b0;
      to_cnt      <= '0;
      // Pretend the other side went last so the first tie follows LSU_FIRST.
      last_grant  <= LSU_FIRST ? GNT_IFU : GNT_LSU;
    end else begin
      M_Request   <= m_req_nxt;
      M_Addr      <= m_addr_nxt;
      Grant       <= grant_nxt;
      IFU_Finish  <= ifu_fin_nxt;
      LSU_Finish  <= lsu_fin_nxt;
      IFU_Data    <= ifu_data_nxt;
      LSU_Data    <= lsu_data_nxt;
      Timeout_Err <= err_nxt;
      to_cnt      <= to_cnt_nxt;
      last_grant  <= last_grant_nxt;
    end
  end

endmodule

// File: doc/axi4_read_arbiter.md
Name: axi4_read_arbiter

Overview:
- Two-requester arbiter in front of the AXI4-lite read path.
- Shares one host-side read port (R_Addr/R_Request/R_Finish/Data_Out) between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Round-robin grant, address latching and response routing.
- Sticky timeout flag when the downstream read does not complete.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, data width of all ports.
- LSU_FIRST, 1, priority used for the first arbitration after reset (1 = LSU wins the first tie).
- TIMEOUT, 1024, cycles in BUSY without M_Finish before Timeout_Err sets; 0 disables the check.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IFU_Addr  in  ADDR_W  IFU read address; stable while IFU_Request is high.
- IFU_Request  in  1  IFU read request; level, held until IFU_Finish.
- IFU_Finish  out  1  one-cycle pulse: IFU read complete.
- IFU_Data  out  DATA_W  IFU read data; valid with IFU_Finish, held until the next IFU completion.
- LSU_Addr  in  ADDR_W  LSU read address.
- LSU_Request  in  1  LSU read request; same rules as IFU.
- LSU_Finish  out  1  one-cycle pulse: LSU read complete.
- LSU_Data  out  DATA_W  LSU read data; same rules as IFU_Data.
- M_Addr  out  ADDR_W  to read-module R_Addr; latched address of the granted requester.
- M_Request  out  1  to read-module R_Request.
- M_Finish  in  1  from read-module R_Finish; one-cycle pulse.
- M_Data  in  DATA_W  from read-module Data_Out; valid when M_Finish is high.
- Grant  out  2  one-hot current owner, {LSU, IFU}; 00 when idle.
- Timeout_Err  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (RST_N low, async): state IDLE; M_Request=0, M_Addr=0, IFU/LSU_Finish=0, IFU/LSU_Data=0, Grant=00, Timeout_Err=0, timeout counter=0, last_grant = LSU_FIRST ? IFU : LSU, so the first tie goes to the LSU_FIRST choice.
- All outputs are registered.
- States: IDLE, BUSY_IFU, BUSY_LSU, DONE.
- IDLE:
  - Exactly one request high: grant it.
  - Both high: grant the port that is not last_grant.
  - On grant: next cycle M_Request=1, M_Addr=latched requester address, Grant set, last_grant updated.
- BUSY_x:
  - M_Request and M_Addr held constant; requester address changes are ignored.
  - Timeout counter increments each cycle. When it reaches TIMEOUT, Timeout_Err sets; the transaction is not aborted and waiting continues.
  - On M_Finish: next cycle x_Finish=1 and x_Data=M_Data. M_Request=0, Grant=00, counter cleared, go to DONE.
- DONE: one cycle. Requests are not sampled, which gives the finished requester a cycle to drop Request. Then go to IDLE.
- Latency: request seen in IDLE at edge N → M_Request high after edge N. M_Finish at edge K → x_Finish high after edge K. Earliest next grant is after edge K+2.
- M_Finish in IDLE or DONE is spurious: ignored, no Finish pulse, data registers unchanged.
- Request dropped mid-BUSY is a protocol violation: the transaction still completes and the Finish pulse is still issued.
- Reset mid-transaction: all state cleared immediately; no Finish pulse for the in-flight read.
- Back-to-back same requester with the other idle: that requester is granted again; round-robin only matters on ties.
- Requester Finish pulses never overlap; at most one Finish per M_Finish.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY_IFU=2'd1, BUSY_LSU=2'd2, DONE=2'd3) and grant one-hot constants (GNT_NONE=2'b00, GNT_IFU=2'b01, GNT_LSU=2'b10). The read-module wrapper and future write arbiter reuse them.
- One natural sub-module, rr_arbiter2: combinational two-way round-robin pick from the two requests and last_grant.
- FSM, latches and timeout counter stay in the top.

Test Plan:
- IFU only, IFU_Addr=0x8000_0000; slave returns 0xDEAD_BEEF_0000_0001 after 3 cycles → M_Addr=0x8000_0000, one IFU_Finish pulse with IFU_Data=0xDEAD_BEEF_0000_0001; LSU_Finish never pulses.
- IFU and LSU raised in the same cycle after reset (LSU_FIRST=1) → LSU granted first (Grant=10). IFU granted after LSU_Finish+DONE. Completion order LSU, IFU; each requester receives only its own data.
- Both held continuously for 4 transactions → grants alternate LSU, IFU, LSU, IFU.
- LSU_Addr changed from 0x1000 to 0x2000 during BUSY_LSU → M_Addr stays 0x1000 until M_Finish.
- TIMEOUT=8, slave never responds → Timeout_Err rises once 8 BUSY cycles have elapsed without M_Finish and stays high. A late M_Finish then still produces a normal Finish.
- RST_N low during BUSY_IFU → M_Request, Grant and Finish outputs are 0 without waiting for a clock edge; a later M_Finish in IDLE produces no Finish pulse.
